hir_memref_server: RTL and testbench
====================================

// Module: hir_memref_server
// PURPOSE
//  Synthesizable responder for the HIR memref port protocol: owns one DEPTH x WIDTH RAM and serves a kernel's
//  read port (p0) and write port (p1) with the same timing as the bench memory models. Adds a host side that
//  preloads the RAM over a valid/ready stream, pulses the kernel start 't', and dumps results after kernel_done.
//  Sits between the host/DMA and one memref argument of an HIR-generated kernel (e.g. matmul img/output).
// PARAMETERS
//  WIDTH   32               data word width
//  DEPTH   64               words in RAM; need not be a power of two
//  ADDR_W  $clog2(DEPTH)    width of all address ports
// PORTS
//  clk           in   1       single clock; all logic on rising edge
//  rst           in   1       synchronous, active-high reset
//  cfg_load      in   1       pulse: start LOAD (honoured only in IDLE)
//  cfg_run       in   1       pulse: start RUN (honoured only in IDLE)
//  cfg_dump      in   1       pulse: start DUMP (honoured only in IDLE)
//  busy          out  1       1 whenever state != IDLE
//  load_valid    in   1       host load word valid
//  load_ready    out  1       1 in LOAD state
//  load_data     in   WIDTH   host load word, written to address = load count
//  t             out  1       one-cycle kernel start pulse
//  kernel_done   in   1       kernel finished; ends RUN
//  p0_addr_en    in   1       interface compatibility only; ignored
//  p0_addr_data  in   ADDR_W  kernel read address
//  p0_rd_en      in   1       kernel read request
//  p0_rd_data    out  WIDTH   read data, valid cycle after p0_rd_en
//  p1_addr_en    in   1       interface compatibility only; ignored
//  p1_addr_data  in   ADDR_W  kernel write address
//  p1_wr_en      in   1       kernel write request
//  p1_wr_data    in   WIDTH   kernel write data
//  dump_valid    out  1       dump word valid
//  dump_ready    in   1       host accepts dump word
//  dump_data     out  WIDTH   dump word
//  dump_last     out  1       with dump_valid: word DEPTH-1
//  addr_err      out  1       sticky: out-of-range kernel access seen
// BEHAVIOUR
//  Reset: state IDLE; busy, load_ready, t, dump_valid, dump_last, addr_err = 0; p0_rd_data = 0; counters 0.
//    RAM contents are NOT reset. Reset mid-LOAD/RUN/DUMP aborts to IDLE; partial loads/writes stay in RAM.
//  FSM IDLE -> LOAD | RUN | DUMP on cfg_*; simultaneous pulses: priority load > run > dump; cfg_* ignored when busy.
//  LOAD: each load_valid&load_ready writes load_data to RAM[cnt], cnt++; after beat DEPTH-1 -> IDLE next cycle.
//    cfg_load also clears addr_err.
//  RUN: t=1 exactly in first RUN cycle. Kernel ports active only in RUN; rd_en/wr_en ignored elsewhere.
//    Read: p0_rd_en at cycle n -> p0_rd_data = RAM[addr] at n+1; held until next accepted read.
//    Write: p1_wr_en at cycle n commits at end of n. Same-address read+write in one cycle: read-first (old data).
//    Address >= DEPTH: read returns 0, write dropped, addr_err set (sticky until rst or cfg_load).
//    kernel_done (any RUN cycle incl. first) -> IDLE next cycle; a write in that cycle still commits.
//  DUMP: read RAM[0..DEPTH-1] in order via sync read + output register; cfg_dump at cycle n -> first
//    dump_valid at n+2. dump_data/dump_last stable while dump_valid & !dump_ready. Sustains 1 word/cycle
//    with dump_ready held high (next read issued in the same cycle as a handshake). After last handshake
//    -> IDLE next cycle, dump_valid deasserts.
//  Width: addresses compared unsigned against DEPTH; load/dump counters are ADDR_W+1 bits to avoid wrap.
// TESTING
//  1 DEPTH=64: cfg_load, load 1..64 with load_valid always high -> busy low 65 cycles after cfg_load; dump -> 1..64, last on 64.
//  2 cfg_run -> t high one cycle; p0_rd_en addr 5 -> p0_rd_data=6 next cycle, held 3 idle cycles; kernel_done -> busy=0.
//  3 RUN: p1 write 0xDEAD@10 and p0 read @10 same cycle -> rd_data=11; read @10 next cycle -> 0xDEAD; dump word10=0xDEAD.
//  4 DUMP with dump_ready toggling 1,0,0,1 pattern -> all 64 words in order, no duplicates/drops, data stable while stalled.
//  5 DEPTH=48: RUN read @50 -> rd_data=0, addr_err=1; write @47 lands; write @60 dropped; cfg_load clears addr_err.
//  6 rst asserted after 20 dump words -> dump_valid=0, busy=0 next cycle; new cfg_dump restarts at word 0; cfg_run during DUMP ignored.

Source files
------------

// File: rtl/hir_memref_server_if.sv
// Host, kernel and dump signals for one hir_memref_server.
// master = host/kernel side, slave = the server.
interface hir_memref_server_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 6
);
    logic              cfg_load;
    logic              cfg_run;
    logic              cfg_dump;
    logic              busy;
    logic              load_valid;
    logic              load_ready;
    logic [WIDTH-1:0]  load_data;
    logic              t;
    logic              kernel_done;
    logic              p0_addr_en;
    logic [ADDR_W-1:0] p0_addr_data;
    logic              p0_rd_en;
    logic [WIDTH-1:0]  p0_rd_data;
    logic              p1_addr_en;
    logic [ADDR_W-1:0] p1_addr_data;
    logic              p1_wr_en;
    logic [WIDTH-1:0]  p1_wr_data;
    logic              dump_valid;
    logic              dump_ready;
    logic [WIDTH-1:0]  dump_data;
    logic              dump_last;
    logic              addr_err;

    modport master (
        output cfg_load, cfg_run, cfg_dump, load_valid, load_data, kernel_done,
               p0_addr_en, p0_addr_data, p0_rd_en,
               p1_addr_en, p1_addr_data, p1_wr_en, p1_wr_data, dump_ready,
        input  busy, load_ready, t, p0_rd_data, dump_valid, dump_data, dump_last, addr_err
    );

    modport slave (
        input  cfg_load, cfg_run, cfg_dump, load_valid, load_data, kernel_done,
               p0_addr_en, p0_addr_data, p0_rd_en,
               p1_addr_en, p1_addr_data, p1_wr_en, p1_wr_data, dump_ready,
        output busy, load_ready, t, p0_rd_data, dump_valid, dump_data, dump_last, addr_err
    );
endinterface

// File: rtl/hir_memref_server.sv
// Memref responder: one DEPTH x WIDTH RAM, host preload/dump streams, kernel p0 read / p1 write.
// Latency: p0 read data 1 cycle after rd_en; dump first word 2 cycles after cfg_dump, stalls on !dump_ready.
module hir_memref_server #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    hir_memref_server_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DUMP} state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = DEPTH_C - 1'b1;

    state_t            state, state_nxt;
    logic [ADDR_W:0]   cnt;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic              p0_ok, p1_ok;
    logic              dump_issue;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              unused_addr_en;

    assign unused_addr_en = bus.p0_addr_en ^ bus.p1_addr_en;

    // Addresses widened by one bit so DEPTH itself is representable in the compare.
    assign p0_ok = {1'b0, bus.p0_addr_data} < DEPTH_C;
    assign p1_ok = {1'b0, bus.p1_addr_data} < DEPTH_C;

    assign bus.busy       = (state != IDLE);
    assign bus.load_ready = (state == LOAD);

    // Issue the next dump read whenever the output register is empty or draining this cycle.
    assign dump_issue = (state == DUMP) && (cnt < DEPTH_C) && (!bus.dump_valid || bus.dump_ready);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.cfg_load)     state_nxt = LOAD;
                else if (bus.cfg_run) state_nxt = RUN;
                else if (bus.cfg_dump) state_nxt = DUMP;
            end
            LOAD: if (bus.load_valid && cnt == LAST_C) state_nxt = IDLE;
            RUN:  if (bus.kernel_done) state_nxt = IDLE;
            DUMP: if (bus.dump_valid && bus.dump_ready && cnt == DEPTH_C) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // LOAD and RUN never overlap, so one write port serves both.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (state == LOAD && bus.load_valid) begin
            mem_we    = 1'b1;
            mem_waddr = cnt[ADDR_W-1:0];
            mem_wdata = bus.load_data;
        end else if (state == RUN && bus.p1_wr_en && p1_ok) begin
            mem_we    = 1'b1;
            mem_waddr = bus.p1_addr_data;
            mem_wdata = bus.p1_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            bus.t          <= 1'b0;
            bus.p0_rd_data <= '0;
            bus.addr_err   <= 1'b0;
            bus.dump_valid <= 1'b0;
            bus.dump_last  <= 1'b0;
            bus.dump_data  <= '0;
        end else begin
            bus.t <= (state == IDLE) && !bus.cfg_load && bus.cfg_run;

            case (state)
                LOAD:    if (bus.load_valid) cnt <= cnt + 1'b1;
                DUMP:    if (dump_issue)     cnt <= cnt + 1'b1;
                default: cnt <= '0;
            endcase

            // Reads sample mem before this edge's write lands, giving read-first behaviour.
            if (state == RUN && bus.p0_rd_en)
                bus.p0_rd_data <= p0_ok ? mem[bus.p0_addr_data] : '0;

            if (state == IDLE && bus.cfg_load)
                bus.addr_err <= 1'b0;
            else if (state == RUN && ((bus.p0_rd_en && !p0_ok) || (bus.p1_wr_en && !p1_ok)))
                bus.addr_err <= 1'b1;

            if (state != DUMP) begin
                bus.dump_valid <= 1'b0;
                bus.dump_last  <= 1'b0;
            end else if (dump_issue) begin
                bus.dump_data  <= mem[cnt[ADDR_W-1:0]];
                bus.dump_valid <= 1'b1;
                bus.dump_last  <= (cnt == LAST_C);
            end else if (bus.dump_ready) begin
                bus.dump_valid <= 1'b0;
                bus.dump_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hir_memref_server.sv
// Directed bench: a 64-deep server for load/run/dump and a 48-deep one for range errors.
module tb_hir_memref_server;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [31:0] model [64];

    hir_memref_server_if #(.WIDTH(32), .ADDR_W(6)) bus_a ();
    hir_memref_server_if #(.WIDTH(32), .ADDR_W(6)) bus_b ();

    hir_memref_server #(.WIDTH(32), .DEPTH(64)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    hir_memref_server #(.WIDTH(32), .DEPTH(48)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd_en;
        logic [5:0]  rd_addr;
        logic        wr_en;
        logic [5:0]  wr_addr;
        logic [31:0] wr_data;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_if(input int which);
        if (which == 0) begin
            bus_a.cfg_load = 0; bus_a.cfg_run = 0; bus_a.cfg_dump = 0;
            bus_a.load_valid = 0; bus_a.load_data = 0; bus_a.kernel_done = 0;
            bus_a.p0_addr_en = 0; bus_a.p0_addr_data = 0; bus_a.p0_rd_en = 0;
            bus_a.p1_addr_en = 0; bus_a.p1_addr_data = 0; bus_a.p1_wr_en = 0;
            bus_a.p1_wr_data = 0; bus_a.dump_ready = 0;
        end else begin
            bus_b.cfg_load = 0; bus_b.cfg_run = 0; bus_b.cfg_dump = 0;
            bus_b.load_valid = 0; bus_b.load_data = 0; bus_b.kernel_done = 0;
            bus_b.p0_addr_en = 0; bus_b.p0_addr_data = 0; bus_b.p0_rd_en = 0;
            bus_b.p1_addr_en = 0; bus_b.p1_addr_data = 0; bus_b.p1_wr_en = 0;
            bus_b.p1_wr_data = 0; bus_b.dump_ready = 0;
        end
    endtask

    // Full dump of dut_a; ready follows pat[cycle % 4]; checks order, last flag and stall stability.
    task automatic do_dump(input logic [3:0] pat);
        int got;
        int cyc;
        logic stalled;
        logic [31:0] held;
        bus_a.cfg_dump = 1'b1;
        bus_a.dump_ready = 1'b0;
        step();
        bus_a.cfg_dump = 1'b0;
        check("dump_valid_n1", bus_a.dump_valid, 0);
        step();
        check("dump_valid_n2", bus_a.dump_valid, 1);
        got = 0; cyc = 0; stalled = 1'b0; held = 0;
        while (got < 64 && cyc < 1000) begin
            if (stalled) begin
                check("dump_hold_valid", bus_a.dump_valid, 1);
                check("dump_hold_data", bus_a.dump_data, held);
            end
            bus_a.dump_ready = pat[cyc % 4];
            stalled = bus_a.dump_valid && !bus_a.dump_ready;
            held = bus_a.dump_data;
            if (bus_a.dump_valid && bus_a.dump_ready) begin
                check("dump_data", bus_a.dump_data, model[got]);
                check("dump_last", bus_a.dump_last, (got == 63));
                got++;
            end
            step();
            cyc++;
        end
        bus_a.dump_ready = 1'b0;
        check("dump_count", got, 64);
        check("dump_end_busy", bus_a.busy, 0);
        check("dump_end_valid", bus_a.dump_valid, 0);
    endtask

    initial begin
        int n;
        int got;
        int cyc;
        total = 0;
        bad = 0;
        idle_if(0);
        idle_if(1);
        for (int i = 0; i < 64; i++) model[i] = i + 1;

        vecs[0] = '{1'b1, 6'd5,  1'b0, 6'd0,  32'h0,    32'd6,    1'b0};
        vecs[1] = '{1'b0, 6'd0,  1'b0, 6'd0,  32'h0,    32'd6,    1'b0};
        vecs[2] = '{1'b0, 6'd9,  1'b0, 6'd0,  32'h0,    32'd6,    1'b0};
        vecs[3] = '{1'b0, 6'd0,  1'b0, 6'd0,  32'h0,    32'd6,    1'b0};
        vecs[4] = '{1'b1, 6'd10, 1'b1, 6'd10, 32'hDEAD, 32'd11,   1'b0};
        vecs[5] = '{1'b1, 6'd10, 1'b0, 6'd0,  32'h0,    32'hDEAD, 1'b0};
        vecs[6] = '{1'b0, 6'd0,  1'b1, 6'd20, 32'h1234, 32'hDEAD, 1'b0};
        vecs[7] = '{1'b1, 6'd20, 1'b0, 6'd0,  32'h0,    32'h1234, 1'b0};
        vecs[8] = '{1'b1, 6'd63, 1'b0, 6'd0,  32'h0,    32'd64,   1'b0};

        rst = 1'b1;
        step();
        step();
        check("rst_busy", bus_a.busy, 0);
        check("rst_load_ready", bus_a.load_ready, 0);
        check("rst_t", bus_a.t, 0);
        check("rst_dump_valid", bus_a.dump_valid, 0);
        check("rst_dump_last", bus_a.dump_last, 0);
        check("rst_addr_err", bus_a.addr_err, 0);
        check("rst_rd_data", bus_a.p0_rd_data, 0);
        rst = 1'b0;

        // Load 1..64 with valid held high.
        bus_a.cfg_load = 1'b1;
        bus_a.load_valid = 1'b1;
        step();
        bus_a.cfg_load = 1'b0;
        check("load_ready", bus_a.load_ready, 1);
        n = 1;
        while (bus_a.busy && n < 200) begin
            bus_a.load_data = n;
            step();
            n++;
        end
        bus_a.load_valid = 1'b0;
        check("load_busy_cycles", n, 65);
        do_dump(4'b1111);

        // Run: table of kernel port cycles.
        bus_a.cfg_run = 1'b1;
        step();
        bus_a.cfg_run = 1'b0;
        check("run_t_first", bus_a.t, 1);
        check("run_busy", bus_a.busy, 1);
        for (int k = 0; k < 9; k++) begin
            bus_a.p0_rd_en     = vecs[k].rd_en;
            bus_a.p0_addr_data = vecs[k].rd_addr;
            bus_a.p1_wr_en     = vecs[k].wr_en;
            bus_a.p1_addr_data = vecs[k].wr_addr;
            bus_a.p1_wr_data   = vecs[k].wr_data;
            step();
            check("vec_rd_data", bus_a.p0_rd_data, vecs[k].exp_rd);
            check("vec_addr_err", bus_a.addr_err, vecs[k].exp_err);
            if (k == 0) check("run_t_second", bus_a.t, 0);
        end
        model[10] = 32'hDEAD;
        model[20] = 32'h1234;
        bus_a.p0_rd_en = 1'b0;
        bus_a.p1_wr_en = 1'b1;
        bus_a.p1_addr_data = 6'd30;
        bus_a.p1_wr_data = 32'hBEEF;
        bus_a.kernel_done = 1'b1;
        step();
        model[30] = 32'hBEEF;
        bus_a.kernel_done = 1'b0;
        check("done_busy", bus_a.busy, 0);
        // Kernel ports outside RUN must be ignored.
        bus_a.p1_addr_data = 6'd31;
        bus_a.p1_wr_data = 32'h5555;
        bus_a.p0_rd_en = 1'b1;
        bus_a.p0_addr_data = 6'd0;
        step();
        bus_a.p0_rd_en = 1'b0;
        bus_a.p1_wr_en = 1'b0;
        check("idle_rd_ignored", bus_a.p0_rd_data, 64);
        do_dump(4'b1001);

        // Reset mid-dump; cfg_run while dumping is ignored.
        bus_a.cfg_dump = 1'b1;
        step();
        bus_a.cfg_dump = 1'b0;
        bus_a.dump_ready = 1'b1;
        got = 0; cyc = 0;
        while (got < 20 && cyc < 200) begin
            bus_a.cfg_run = (cyc == 3);
            if (bus_a.dump_valid) begin
                if (got == 19) check("pre_rst_word", bus_a.dump_data, model[19]);
                got++;
            end
            step();
            cyc++;
            if (cyc == 4) check("run_ignored_t", bus_a.t, 0);
        end
        bus_a.cfg_run = 1'b0;
        check("pre_rst_count", got, 20);
        check("pre_rst_busy", bus_a.busy, 1);
        rst = 1'b1;
        bus_a.dump_ready = 1'b0;
        step();
        rst = 1'b0;
        check("mid_rst_valid", bus_a.dump_valid, 0);
        check("mid_rst_busy", bus_a.busy, 0);
        do_dump(4'b1111);

        // DEPTH=48 range errors.
        bus_b.cfg_run = 1'b1;
        step();
        bus_b.cfg_run = 1'b0;
        bus_b.p1_wr_en = 1'b1; bus_b.p1_addr_data = 6'd47; bus_b.p1_wr_data = 32'hAAAA;
        step();
        bus_b.p1_addr_data = 6'd12; bus_b.p1_wr_data = 32'h1111;
        step();
        bus_b.p1_wr_en = 1'b0;
        bus_b.p0_rd_en = 1'b1; bus_b.p0_addr_data = 6'd47;
        step();
        check("b_rd47", bus_b.p0_rd_data, 32'hAAAA);
        check("b_err_clean", bus_b.addr_err, 0);
        bus_b.p0_addr_data = 6'd50;
        step();
        check("b_rd50", bus_b.p0_rd_data, 0);
        check("b_err_rd", bus_b.addr_err, 1);
        bus_b.p0_rd_en = 1'b0;
        bus_b.p1_wr_en = 1'b1; bus_b.p1_addr_data = 6'd60; bus_b.p1_wr_data = 32'h7777;
        step();
        bus_b.p1_wr_en = 1'b0;
        bus_b.p0_rd_en = 1'b1; bus_b.p0_addr_data = 6'd12;
        step();
        check("b_rd12", bus_b.p0_rd_data, 32'h1111);
        bus_b.p0_addr_data = 6'd47;
        step();
        check("b_rd47_again", bus_b.p0_rd_data, 32'hAAAA);
        bus_b.p0_rd_en = 1'b0;
        bus_b.kernel_done = 1'b1;
        step();
        bus_b.kernel_done = 1'b0;
        check("b_done_busy", bus_b.busy, 0);
        check("b_err_sticky", bus_b.addr_err, 1);
        bus_b.cfg_load = 1'b1;
        bus_b.load_valid = 1'b1;
        step();
        bus_b.cfg_load = 1'b0;
        check("b_err_cleared", bus_b.addr_err, 0);
        n = 1;
        while (bus_b.busy && n < 200) begin
            bus_b.load_data = n;
            step();
            n++;
        end
        bus_b.load_valid = 1'b0;
        check("b_load_cycles", n, 49);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
